issue_hazard_scoreboard: RTL and testbench
==========================================

# issue_hazard_scoreboard

Parametrised N-way in-order issue hazard unit. It sits between decode and execute in the superscalar pipeline and replaces purely combinational EX/MEM destination matching with a registered per-architectural-register scoreboard. Each cycle it decides how many leading decode ways may issue. It also produces a forwarding source (pipeline age and producing way) for every source operand, and ages in-flight writes as the pipeline advances.

## Interface
Parameters:
- WAYS, 3, issue width (number of decode ways); way 0 is oldest.
- FWD_DEPTH, 2, number of forwarding stages after ID (1 = EX, 2 = MEM, …); after this the value is in the register file.
- LOAD_LAT, 2, minimum age at which a load result is forwardable (1 ≤ LOAD_LAT ≤ FWD_DEPTH).
- AW = $clog2(FWD_DEPTH+1) and WW = max(1,$clog2(WAYS)), derived, not overridable.

Ports (clock and reset first; one clock, reset synchronous active-high):
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high; clears scoreboard.
- flush  in  1  branch/exception squash; clears scoreboard at next edge.
- hold  in  1  pipeline frozen this cycle (downstream stall).
- id_valid  in  WAYS  decode way holds a real instruction.
- id_rs1, id_rs2  in  WAYS×5  source register indices per way.
- id_dest  in  WAYS×5  destination register per way.
- id_wr  in  WAYS  way writes id_dest.
- id_rd_mem  in  WAYS  way is a load.
- issue_count  out  $clog2(WAYS+1)  number of leading ways issued this cycle.
- rollback  out  $clog2(WAYS+1)  WAYS − issue_count.
- fwd_age_a, fwd_age_b  out  WAYS×AW  per-way operand source age; 0 = register file.
- fwd_way_a, fwd_way_b  out  WAYS×WW  producing way when age ≠ 0, else 0.
- load_stall_cnt  out  32  cycles in which a load-use hazard limited issue.

## Operation
- State per register r in 1..31: age[r] (0..FWD_DEPTH), way[r], load[r]. x0 has no entry, never hazards, is never written.
- Operand hazard for way i reading r≠0, valid way:
  - intra-group RAW: some valid way j<i with id_wr[j] and id_dest[j]==r;
  - load-use: age[r]≠0, load[r]=1, age[r]<LOAD_LAT.
- issue_count = index of first valid way with any operand hazard, else WAYS. Invalid ways never hazard and never write. In-order: no way after the first hazard issues.
- Forwarding outputs reflect scoreboard state only: fwd_age = age[r], fwd_way = way[r]; r==0 or age 0 gives 0/0. Not masked by hazards.
- Update at rising edge, priority reset > flush > hold > normal:
  - reset or flush: all age=0, way=0, load=0.
  - hold: state unchanged; no writes recorded.
  - normal: every age≠0 increments; FWD_DEPTH wraps to 0 (retired to regfile). Then each issued way k<issue_count with id_wr, dest d≠0 sets age[d]=1, way[d]=k, load[d]=id_rd_mem[k]. The highest such k wins on WAW. A new write overrides aging of the same register.
- load_stall_cnt: +1 on edges where not reset/flush/hold and the first-hazard way's hazard includes load-use. Saturates at 2^32−1. Cleared by reset only.

## Timing
- All outputs combinational from registered state plus current inputs; zero-cycle decision latency.
- While reset=1 or hold=1: issue_count=0, rollback=WAYS. fwd_* still show state. While flush=1: issue_count=0.
- After reset: all ages 0, fwd_* 0, load_stall_cnt 0; issue_count = WAYS for a hazard-free group.
- Producer issued at edge N: consumer sees age 1 in cycle N+1, age 2 in N+2, regfile from age FWD_DEPTH+1 (age 0).
- Load issued at edge N with LOAD_LAT=2: dependent issue blocked in cycle N+1, allowed in N+2 with fwd_age=2.
- Hold freezes aging, so a held load remains unforwardable for the whole hold.

## Test plan
WAYS=3, FWD_DEPTH=2, LOAD_LAT=2:
- Reset 2 cycles, then 3 valid independent ALU ops (dest x1,x2,x3; sources x10..x15) -> issue_count=3, rollback=0, all fwd_* 0.
- Way0 writes x5, way1 reads rs1=x5 -> issue_count=1, rollback=2. Next cycle consumer presented as way0 -> issue_count≥1, fwd_age_a=1, fwd_way_a=0.
- Way2 load to x7 issues. Next cycle way0 rs2=x7 -> issue_count=0, rollback=3, load_stall_cnt +1. Following cycle -> issues with fwd_age_b=2, fwd_way_b=2. Cycle after -> fwd_age_b=0.
- Way0 dest x0 with id_wr, way1 rs1=x0/rs2=x0 -> issue_count=3, fwd ages 0, no scoreboard change.
- Load to x3 issues, then hold=1 for 3 cycles -> issue_count=0, fwd_age for x3 stays 1. Release -> consumer still blocked one cycle, then issues with age 2.
- Way0 load x4 and way1 ALU x4 issue together -> way[4]=1, load[4]=0, so a next-cycle reader issues with age 1. Flush next cycle -> all fwd_age 0 afterwards. Reset mid-stall -> load_stall_cnt=0.

Source files
------------

// File: rtl/issue_hazard_scoreboard_if.sv
// Decode-to-hazard-unit bundle: per-way decode info in, issue decision and
// per-operand forwarding selects out.
interface issue_hazard_scoreboard_if #(
    parameter int WAYS      = 3,
    parameter int FWD_DEPTH = 2
);
    localparam int AW = $clog2(FWD_DEPTH + 1);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW = $clog2(WAYS + 1);

    logic                      flush;
    logic                      hold;
    logic [WAYS-1:0]           id_valid;
    logic [WAYS-1:0][4:0]      id_rs1;
    logic [WAYS-1:0][4:0]      id_rs2;
    logic [WAYS-1:0][4:0]      id_dest;
    logic [WAYS-1:0]           id_wr;
    logic [WAYS-1:0]           id_rd_mem;

    logic [CW-1:0]             issue_count;
    logic [CW-1:0]             rollback;
    logic [WAYS-1:0][AW-1:0]   fwd_age_a;
    logic [WAYS-1:0][AW-1:0]   fwd_age_b;
    logic [WAYS-1:0][WW-1:0]   fwd_way_a;
    logic [WAYS-1:0][WW-1:0]   fwd_way_b;
    logic [31:0]               load_stall_cnt;

    modport master (
        output flush, hold, id_valid, id_rs1, id_rs2, id_dest, id_wr, id_rd_mem,
        input  issue_count, rollback, fwd_age_a, fwd_age_b, fwd_way_a, fwd_way_b,
               load_stall_cnt
    );

    modport slave (
        input  flush, hold, id_valid, id_rs1, id_rs2, id_dest, id_wr, id_rd_mem,
        output issue_count, rollback, fwd_age_a, fwd_age_b, fwd_way_a, fwd_way_b,
               load_stall_cnt
    );
endinterface

// File: rtl/issue_hazard_scoreboard.sv
// N-way in-order issue hazard unit with a registered per-register scoreboard
// tracking age, producing way and load-ness of in-flight writes.
module issue_hazard_scoreboard #(
    parameter int WAYS      = 3,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    issue_hazard_scoreboard_if.slave bus
);
    localparam int AW = $clog2(FWD_DEPTH + 1);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW = $clog2(WAYS + 1);
    localparam logic [AW-1:0] DEPTH = AW'(FWD_DEPTH);
    localparam logic [AW-1:0] LLAT  = AW'(LOAD_LAT);

    // Entry 0 is never written, so it stays at age 0 and never hazards.
    logic [AW-1:0] age_q [32];
    logic [AW-1:0] age_d [32];
    logic [WW-1:0] way_q [32];
    logic [WW-1:0] way_d [32];
    logic [31:0]   load_q, load_d;
    logic [31:0]   stall_q, stall_d;

    logic [WAYS-1:0] hz, hz_ld;
    logic [CW-1:0]   first_hz, issue_cnt;
    logic            first_is_ld, found;
    logic [4:0]      r;

    always_comb begin : hazard_detect
        hz    = '0;
        hz_ld = '0;
        r     = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            for (int unsigned op = 0; op < 2; op++) begin
                r = (op == 0) ? bus.id_rs1[i] : bus.id_rs2[i];
                if (bus.id_valid[i] && r != 5'd0) begin
                    if (age_q[r] != '0 && load_q[r] && age_q[r] < LLAT)
                        hz_ld[i] = 1'b1;
                    for (int unsigned j = 0; j < i; j++)
                        if (bus.id_valid[j] && bus.id_wr[j] && bus.id_dest[j] == r)
                            hz[i] = 1'b1;
                end
            end
            hz[i] = hz[i] | hz_ld[i];
        end

        first_hz    = CW'(WAYS);
        first_is_ld = 1'b0;
        found       = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!found && hz[i]) begin
                found       = 1'b1;
                first_hz    = CW'(i);
                first_is_ld = hz_ld[i];
            end
        end

        issue_cnt = (reset || bus.flush || bus.hold) ? '0 : first_hz;
    end

    assign bus.issue_count    = issue_cnt;
    assign bus.rollback       = CW'(WAYS) - issue_cnt;
    assign bus.load_stall_cnt = stall_q;

    always_comb begin : fwd_select
        bus.fwd_age_a = '0;
        bus.fwd_age_b = '0;
        bus.fwd_way_a = '0;
        bus.fwd_way_b = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (bus.id_rs1[i] != 5'd0 && age_q[bus.id_rs1[i]] != '0) begin
                bus.fwd_age_a[i] = age_q[bus.id_rs1[i]];
                bus.fwd_way_a[i] = way_q[bus.id_rs1[i]];
            end
            if (bus.id_rs2[i] != 5'd0 && age_q[bus.id_rs2[i]] != '0) begin
                bus.fwd_age_b[i] = age_q[bus.id_rs2[i]];
                bus.fwd_way_b[i] = way_q[bus.id_rs2[i]];
            end
        end
    end

    always_comb begin : next_state
        age_d   = age_q;
        way_d   = way_q;
        load_d  = load_q;
        stall_d = stall_q;
        if (bus.flush) begin
            for (int unsigned k = 0; k < 32; k++) begin
                age_d[k] = '0;
                way_d[k] = '0;
            end
            load_d = '0;
        end else if (!bus.hold) begin
            for (int unsigned k = 1; k < 32; k++)
                if (age_q[k] != '0)
                    age_d[k] = (age_q[k] == DEPTH) ? '0 : age_q[k] + AW'(1);
            // Ascending order lets the youngest issued writer win a WAW.
            for (int unsigned k = 0; k < WAYS; k++) begin
                if (CW'(k) < issue_cnt && bus.id_valid[k] && bus.id_wr[k] &&
                    bus.id_dest[k] != 5'd0) begin
                    age_d[bus.id_dest[k]]  = AW'(1);
                    way_d[bus.id_dest[k]]  = WW'(k);
                    load_d[bus.id_dest[k]] = bus.id_rd_mem[k];
                end
            end
            if (found && first_is_ld && stall_q != '1)
                stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < 32; k++) begin
                age_q[k] <= '0;
                way_q[k] <= '0;
            end
            load_q  <= '0;
            stall_q <= '0;
        end else begin
            age_q   <= age_d;
            way_q   <= way_d;
            load_q  <= load_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_issue_hazard_scoreboard.sv
// Bench for issue_hazard_scoreboard: directed scenarios with fixed expectations,
// then randomized traffic against a "cycles since write" reference model.
module tb_issue_hazard_scoreboard;
    localparam int WAYS = 3;
    localparam int FD   = 2;
    localparam int LL   = 2;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    issue_hazard_scoreboard_if #(.WAYS(WAYS), .FWD_DEPTH(FD)) bus ();

    issue_hazard_scoreboard #(.WAYS(WAYS), .FWD_DEPTH(FD), .LOAD_LAT(LL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: a live register remembers how many advancing edges ago it was written.
    bit              m_live [32];
    int              m_since[32];
    int              m_way  [32];
    bit              m_ld   [32];
    longint unsigned m_cnt;

    function automatic int m_age(input int r);
        if (r == 0 || !m_live[r]) return 0;
        return m_since[r];
    endfunction

    function automatic int m_fway(input int r);
        return (m_age(r) != 0) ? m_way[r] : 0;
    endfunction

    function automatic bit m_ldhz(input int r);
        return m_age(r) != 0 && m_ld[r] && m_age(r) < LL;
    endfunction

    function automatic bit m_rawhz(input int i, input int r);
        if (r == 0) return 0;
        for (int j = 0; j < i; j++)
            if (bus.id_valid[j] && bus.id_wr[j] && int'(bus.id_dest[j]) == r) return 1;
        return 0;
    endfunction

    function automatic int m_first();
        for (int i = 0; i < WAYS; i++) begin
            if (bus.id_valid[i]) begin
                if (m_ldhz(int'(bus.id_rs1[i])) || m_ldhz(int'(bus.id_rs2[i])) ||
                    m_rawhz(i, int'(bus.id_rs1[i])) || m_rawhz(i, int'(bus.id_rs2[i])))
                    return i;
            end
        end
        return WAYS;
    endfunction

    function automatic bit m_first_ld();
        int i;
        i = m_first();
        if (i == WAYS) return 0;
        return m_ldhz(int'(bus.id_rs1[i])) || m_ldhz(int'(bus.id_rs2[i]));
    endfunction

    function automatic int m_issue();
        if (reset || bus.flush || bus.hold) return 0;
        return m_first();
    endfunction

    task automatic tick();
        int n;
        bit lu;
        n  = m_issue();
        lu = m_first_ld();
        @(posedge clock);
        if (reset) begin
            for (int r = 0; r < 32; r++) m_live[r] = 0;
            m_cnt = 0;
        end else if (bus.flush) begin
            for (int r = 0; r < 32; r++) m_live[r] = 0;
        end else if (!bus.hold) begin
            if (lu && m_cnt != 64'hFFFF_FFFF) m_cnt++;
            for (int r = 1; r < 32; r++) begin
                if (m_live[r]) begin
                    m_since[r]++;
                    if (m_since[r] > FD) m_live[r] = 0;
                end
            end
            for (int k = 0; k < n; k++) begin
                if (bus.id_valid[k] && bus.id_wr[k] && bus.id_dest[k] != 5'd0) begin
                    m_live[bus.id_dest[k]]  = 1;
                    m_since[bus.id_dest[k]] = 1;
                    m_way[bus.id_dest[k]]   = k;
                    m_ld[bus.id_dest[k]]    = bus.id_rd_mem[k];
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush = 0; bus.hold = 0;
        bus.id_valid = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_dest = '0; bus.id_wr = '0; bus.id_rd_mem = '0;
    endtask

    task automatic set_way(input int i, input int rs1, input int rs2, input int dest,
                           input bit wr, input bit ld);
        bus.id_valid[i]  = 1'b1;
        bus.id_rs1[i]    = 5'(rs1);
        bus.id_rs2[i]    = 5'(rs2);
        bus.id_dest[i]   = 5'(dest);
        bus.id_wr[i]     = wr;
        bus.id_rd_mem[i] = ld;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #1;
        checks++;
        if (bus.issue_count !== 0 || bus.rollback !== 3) begin
            failures++;
            $display("FAIL reset_issue: got %0d/%0d expected 0/3", bus.issue_count, bus.rollback);
        end
        tick(); tick();
        reset = 0;
        #1;
        checks++;
        if (bus.load_stall_cnt !== 0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.load_stall_cnt);
        end
        checks++;
        if (bus.issue_count !== 3) begin
            failures++;
            $display("FAIL reset_idle_issue: got %0d expected 3", bus.issue_count);
        end
    endtask

    task automatic test_independent();
        clear_inputs();
        set_way(0, 10, 11, 1, 1, 0);
        set_way(1, 12, 13, 2, 1, 0);
        set_way(2, 14, 15, 3, 1, 0);
        #1;
        checks++;
        if (bus.issue_count !== 3 || bus.rollback !== 0) begin
            failures++;
            $display("FAIL indep_issue: got %0d/%0d expected 3/0", bus.issue_count, bus.rollback);
        end
        checks++;
        if (bus.fwd_age_a !== '0 || bus.fwd_age_b !== '0 || bus.fwd_way_a !== '0 || bus.fwd_way_b !== '0) begin
            failures++;
            $display("FAIL indep_fwd: got %h %h %h %h expected all 0",
                     bus.fwd_age_a, bus.fwd_age_b, bus.fwd_way_a, bus.fwd_way_b);
        end
        tick();
    endtask

    task automatic test_raw_intra();
        clear_inputs();
        set_way(0, 10, 11, 5, 1, 0);
        set_way(1, 5, 12, 6, 1, 0);
        set_way(2, 13, 14, 9, 1, 0);
        #1;
        checks++;
        if (bus.issue_count !== 1 || bus.rollback !== 2) begin
            failures++;
            $display("FAIL raw_issue: got %0d/%0d expected 1/2", bus.issue_count, bus.rollback);
        end
        tick();
        clear_inputs();
        set_way(0, 5, 12, 6, 0, 0);
        #1;
        checks++;
        if (bus.issue_count !== 3 || bus.fwd_age_a[0] !== 1 || bus.fwd_way_a[0] !== 0) begin
            failures++;
            $display("FAIL raw_fwd: got issue=%0d age=%0d way=%0d expected 3/1/0",
                     bus.issue_count, bus.fwd_age_a[0], bus.fwd_way_a[0]);
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_way(0, 10, 11, 20, 1, 0);
        set_way(1, 12, 13, 21, 1, 0);
        set_way(2, 14, 15, 7, 1, 1);
        #1;
        checks++;
        if (bus.issue_count !== 3) begin
            failures++;
            $display("FAIL load_issue: got %0d expected 3", bus.issue_count);
        end
        tick();
        clear_inputs();
        set_way(0, 12, 7, 22, 0, 0);
        #1;
        checks++;
        if (bus.issue_count !== 0 || bus.rollback !== 3) begin
            failures++;
            $display("FAIL load_stall: got %0d/%0d expected 0/3", bus.issue_count, bus.rollback);
        end
        tick();
        checks++;
        if (bus.load_stall_cnt !== 1) begin
            failures++;
            $display("FAIL load_cnt: got %0d expected 1", bus.load_stall_cnt);
        end
        checks++;
        if (bus.issue_count !== 3 || bus.fwd_age_b[0] !== 2 || bus.fwd_way_b[0] !== 2) begin
            failures++;
            $display("FAIL load_fwd: got issue=%0d age=%0d way=%0d expected 3/2/2",
                     bus.issue_count, bus.fwd_age_b[0], bus.fwd_way_b[0]);
        end
        tick();
        checks++;
        if (bus.fwd_age_b[0] !== 0 || bus.fwd_way_b[0] !== 0) begin
            failures++;
            $display("FAIL load_retired: got age=%0d way=%0d expected 0/0",
                     bus.fwd_age_b[0], bus.fwd_way_b[0]);
        end
    endtask

    task automatic test_x0();
        clear_inputs();
        set_way(0, 10, 11, 0, 1, 1);
        set_way(1, 0, 0, 23, 1, 0);
        set_way(2, 12, 13, 24, 1, 0);
        #1;
        checks++;
        if (bus.issue_count !== 3 || bus.fwd_age_a[1] !== 0 || bus.fwd_age_b[1] !== 0) begin
            failures++;
            $display("FAIL x0: got issue=%0d ages=%0d/%0d expected 3/0/0",
                     bus.issue_count, bus.fwd_age_a[1], bus.fwd_age_b[1]);
        end
        tick();
        clear_inputs();
        set_way(0, 0, 0, 25, 0, 0);
        #1;
        checks++;
        if (bus.issue_count !== 3 || bus.fwd_age_a[0] !== 0 || bus.fwd_age_b[0] !== 0) begin
            failures++;
            $display("FAIL x0_after: got issue=%0d ages=%0d/%0d expected 3/0/0",
                     bus.issue_count, bus.fwd_age_a[0], bus.fwd_age_b[0]);
        end
        tick();
    endtask

    task automatic test_hold();
        clear_inputs();
        set_way(0, 10, 11, 3, 1, 1);
        #1;
        tick();
        clear_inputs();
        set_way(0, 3, 10, 26, 0, 0);
        bus.hold = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.issue_count !== 0 || bus.rollback !== 3 || bus.fwd_age_a[0] !== 1) begin
                failures++;
                $display("FAIL hold_c%0d: got issue=%0d rb=%0d age=%0d expected 0/3/1",
                         c, bus.issue_count, bus.rollback, bus.fwd_age_a[0]);
            end
            tick();
        end
        checks++;
        if (bus.load_stall_cnt !== 1) begin
            failures++;
            $display("FAIL hold_cnt: got %0d expected 1", bus.load_stall_cnt);
        end
        bus.hold = 0;
        #1;
        checks++;
        if (bus.issue_count !== 0) begin
            failures++;
            $display("FAIL hold_release_block: got %0d expected 0", bus.issue_count);
        end
        tick();
        checks++;
        if (bus.issue_count !== 3 || bus.fwd_age_a[0] !== 2 || bus.load_stall_cnt !== 2) begin
            failures++;
            $display("FAIL hold_release_issue: got issue=%0d age=%0d cnt=%0d expected 3/2/2",
                     bus.issue_count, bus.fwd_age_a[0], bus.load_stall_cnt);
        end
        tick();
    endtask

    task automatic test_waw_flush();
        clear_inputs();
        set_way(0, 10, 11, 4, 1, 1);
        set_way(1, 12, 13, 4, 1, 0);
        #1;
        checks++;
        if (bus.issue_count !== 3) begin
            failures++;
            $display("FAIL waw_issue: got %0d expected 3", bus.issue_count);
        end
        tick();
        clear_inputs();
        set_way(0, 4, 10, 27, 0, 0);
        #1;
        checks++;
        if (bus.issue_count !== 3 || bus.fwd_age_a[0] !== 1 || bus.fwd_way_a[0] !== 1) begin
            failures++;
            $display("FAIL waw_fwd: got issue=%0d age=%0d way=%0d expected 3/1/1",
                     bus.issue_count, bus.fwd_age_a[0], bus.fwd_way_a[0]);
        end
        bus.flush = 1;
        #1;
        checks++;
        if (bus.issue_count !== 0 || bus.fwd_age_a[0] !== 1) begin
            failures++;
            $display("FAIL flush_during: got issue=%0d age=%0d expected 0/1",
                     bus.issue_count, bus.fwd_age_a[0]);
        end
        tick();
        bus.flush = 0;
        #1;
        checks++;
        if (bus.fwd_age_a[0] !== 0 || bus.fwd_way_a[0] !== 0 || bus.issue_count !== 3) begin
            failures++;
            $display("FAIL flush_after: got age=%0d way=%0d issue=%0d expected 0/0/3",
                     bus.fwd_age_a[0], bus.fwd_way_a[0], bus.issue_count);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        set_way(0, 10, 11, 8, 1, 1);
        #1;
        tick();
        clear_inputs();
        set_way(0, 8, 11, 28, 0, 0);
        #1;
        tick();
        checks++;
        if (bus.load_stall_cnt !== 3) begin
            failures++;
            $display("FAIL midstall_cnt: got %0d expected 3", bus.load_stall_cnt);
        end
        reset = 1;
        #1;
        checks++;
        if (bus.issue_count !== 0 || bus.rollback !== 3) begin
            failures++;
            $display("FAIL midstall_reset: got %0d/%0d expected 0/3", bus.issue_count, bus.rollback);
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if (bus.load_stall_cnt !== 0 || bus.fwd_age_a[0] !== 0) begin
            failures++;
            $display("FAIL midstall_cleared: got cnt=%0d age=%0d expected 0/0",
                     bus.load_stall_cnt, bus.fwd_age_a[0]);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 500; cyc++) begin
            clear_inputs();
            for (int i = 0; i < WAYS; i++) begin
                bus.id_valid[i]  = ($urandom_range(0, 7) != 0);
                bus.id_rs1[i]    = 5'($urandom_range(0, 7));
                bus.id_rs2[i]    = 5'($urandom_range(0, 7));
                bus.id_dest[i]   = 5'($urandom_range(0, 7));
                bus.id_wr[i]     = ($urandom_range(0, 3) != 0);
                bus.id_rd_mem[i] = ($urandom_range(0, 2) == 0);
            end
            bus.hold  = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if (bus.issue_count !== m_issue() || bus.rollback !== WAYS - m_issue()) begin
                failures++;
                $display("FAIL rand_issue c%0d: got %0d/%0d expected %0d/%0d", cyc,
                         bus.issue_count, bus.rollback, m_issue(), WAYS - m_issue());
            end
            checks++;
            if (longint'(bus.load_stall_cnt) !== m_cnt) begin
                failures++;
                $display("FAIL rand_cnt c%0d: got %0d expected %0d", cyc, bus.load_stall_cnt, m_cnt);
            end
            for (int i = 0; i < WAYS; i++) begin
                checks++;
                if (bus.fwd_age_a[i] !== m_age(int'(bus.id_rs1[i])) ||
                    bus.fwd_way_a[i] !== m_fway(int'(bus.id_rs1[i]))) begin
                    failures++;
                    $display("FAIL rand_fwd_a c%0d w%0d: got %0d/%0d expected %0d/%0d", cyc, i,
                             bus.fwd_age_a[i], bus.fwd_way_a[i],
                             m_age(int'(bus.id_rs1[i])), m_fway(int'(bus.id_rs1[i])));
                end
                checks++;
                if (bus.fwd_age_b[i] !== m_age(int'(bus.id_rs2[i])) ||
                    bus.fwd_way_b[i] !== m_fway(int'(bus.id_rs2[i]))) begin
                    failures++;
                    $display("FAIL rand_fwd_b c%0d w%0d: got %0d/%0d expected %0d/%0d", cyc, i,
                             bus.fwd_age_b[i], bus.fwd_way_b[i],
                             m_age(int'(bus.id_rs2[i])), m_fway(int'(bus.id_rs2[i])));
                end
            end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        m_cnt = 0;
        for (int r = 0; r < 32; r++) begin
            m_live[r] = 0; m_since[r] = 0; m_way[r] = 0; m_ld[r] = 0;
        end
        clear_inputs();
        @(posedge clock);
        #1;
        test_reset();
        test_independent();
        test_raw_intra();
        test_load_use();
        test_x0();
        test_hold();
        test_waw_flush();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
